// File: rtl/ex_flag_stage.sv
// EX->MEM boundary register with the {Z,V,N} flag register, branch-condition evaluation and sticky halt.
// Optional macro FLAG_BYPASS_EN: branch evaluation sees the flags being written this cycle.
module ex_flag_stage #(
  parameter int          DATA_W   = 16,
  parameter logic [2:0]  FLAG_RST = 3'b000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [3:0]        ex_opcode,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_ovf,
  input  logic [3:0]        ex_dst,
  input  logic              ex_wr_en,
  input  logic              stall,
  input  logic              flush,
  input  logic              br_eval,
  input  logic [2:0]        br_cond,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_result,
  output logic [3:0]        mem_dst,
  output logic              mem_wr_en,
  output logic [2:0]        flags,
  output logic              br_taken,
  output logic              halted
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Flags are packed {Z,V,N}; GE reduces to Z | ~N.
  function automatic logic cond_eval(input logic [2:0] cond, input logic [2:0] f);
    logic z, v, n;
    z = f[2];
    v = f[1];
    n = f[0];
    case (cond)
      3'b000:  cond_eval = ~z;
      3'b001:  cond_eval = z;
      3'b010:  cond_eval = ~z & ~n;
      3'b011:  cond_eval = n;
      3'b100:  cond_eval = z | (~z & ~n);
      3'b101:  cond_eval = n | z;
      3'b110:  cond_eval = v;
      default: cond_eval = 1'b1;
    endcase
  endfunction

  // ---- stage p0: EX-side decode, flag next-state, branch evaluation ----
  logic       load_p0;
  logic       is_hlt_p0;
  logic       res_zero_p0;
  logic [2:0] flags_nxt_p0;
  logic [2:0] flags_br_p0;

  assign load_p0     = ~flush & ~stall & ex_valid & ~halted;
  assign is_hlt_p0   = (ex_opcode == OP_HLT);
  assign res_zero_p0 = (ex_result == '0);

  always_comb begin
    flags_nxt_p0 = flags;
    if (load_p0) begin
      case (ex_opcode)
        OP_ADD, OP_SUB:
          flags_nxt_p0 = {res_zero_p0, ex_ovf, ex_result[DATA_W-1]};
        OP_XOR, OP_SLL, OP_SRA, OP_ROR:
          flags_nxt_p0 = {res_zero_p0, flags[1], flags[0]};
        default:
          flags_nxt_p0 = flags;
      endcase
    end
  end

`ifdef FLAG_BYPASS_EN
  assign flags_br_p0 = flags_nxt_p0;
`else
  assign flags_br_p0 = flags;
`endif

  assign br_taken = br_eval & cond_eval(br_cond, flags_br_p0);

  // ---- stage p1: MEM-side registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid  <= 1'b0;
      mem_result <= '0;
      mem_dst    <= '0;
      mem_wr_en  <= 1'b0;
      flags      <= FLAG_RST;
      halted     <= 1'b0;
    end else if (flush) begin
      mem_valid <= 1'b0;
      mem_wr_en <= 1'b0;
    end else if (!stall) begin
      if (load_p0) begin
        mem_valid  <= 1'b1;
        mem_result <= ex_result;
        mem_dst    <= ex_dst;
        // HLT retires as a valid slot but never writes the register file.
        mem_wr_en  <= ex_wr_en & ~is_hlt_p0;
        flags      <= flags_nxt_p0;
        if (is_hlt_p0)
          halted <= 1'b1;
      end else begin
        mem_valid <= 1'b0;
        mem_wr_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_flag_stage.sv
// Self-checking bench for ex_flag_stage: directed scenarios plus randomized traffic against a rule-level model.
module tb_ex_flag_stage;

  localparam int         DATA_W   = 16;
  localparam logic [2:0] FLAG_RST = 3'b000;
`ifdef FLAG_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, XOR = 4'b0010, SLL = 4'b0100,
                         SRA = 4'b0101, ROR = 4'b0110, HLT = 4'b1111;

  logic              clk = 1'b0;
  logic              rst, ex_valid, ex_ovf, ex_wr_en, stall, flush, br_eval;
  logic [3:0]        ex_opcode, ex_dst;
  logic [DATA_W-1:0] ex_result;
  logic [2:0]        br_cond;
  logic              mem_valid, mem_wr_en, br_taken, halted;
  logic [DATA_W-1:0] mem_result;
  logic [3:0]        mem_dst;
  logic [2:0]        flags;

  int errors = 0;
  int checks = 0;

  // Reference state: what MEM should be holding after each edge.
  logic              e_valid, e_wr, e_halt;
  logic [DATA_W-1:0] e_result;
  logic [3:0]        e_dst;
  logic [2:0]        e_flags;

  ex_flag_stage #(.DATA_W(DATA_W), .FLAG_RST(FLAG_RST)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_result(ex_result),
    .ex_ovf(ex_ovf), .ex_dst(ex_dst), .ex_wr_en(ex_wr_en), .stall(stall), .flush(flush),
    .br_eval(br_eval), .br_cond(br_cond), .mem_valid(mem_valid), .mem_result(mem_result),
    .mem_dst(mem_dst), .mem_wr_en(mem_wr_en), .flags(flags), .br_taken(br_taken), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic bit cond_true(input logic [2:0] c, input logic [2:0] f);
    bit z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit loading();
    return !flush && !stall && ex_valid && !e_halt;
  endfunction

  function automatic logic [2:0] flags_after();
    if (!loading()) return e_flags;
    if (ex_opcode == ADD || ex_opcode == SUB)
      return {ex_result == 0, ex_ovf, ex_result[DATA_W-1]};
    if (ex_opcode == XOR || ex_opcode == SLL || ex_opcode == SRA || ex_opcode == ROR)
      return {ex_result == 0, e_flags[1], e_flags[0]};
    return e_flags;
  endfunction

  function automatic logic exp_br();
    logic [2:0] f;
    f = BYPASS ? flags_after() : e_flags;
    return br_eval && cond_true(br_cond, f);
  endfunction

  // Advance one clock and move the reference model by the same rules.
  task automatic tick();
    logic              n_valid, n_wr, n_halt;
    logic [DATA_W-1:0] n_result;
    logic [3:0]        n_dst;
    logic [2:0]        n_flags;
    n_valid = e_valid; n_wr = e_wr; n_halt = e_halt;
    n_result = e_result; n_dst = e_dst; n_flags = e_flags;
    if (rst) begin
      n_valid = 0; n_wr = 0; n_halt = 0; n_result = 0; n_dst = 0; n_flags = FLAG_RST;
    end else if (flush) begin
      n_valid = 0; n_wr = 0;
    end else if (stall) begin
      // everything holds
    end else if (loading()) begin
      n_valid  = 1;
      n_result = ex_result;
      n_dst    = ex_dst;
      n_wr     = ex_wr_en && (ex_opcode != HLT);
      n_flags  = flags_after();
      if (ex_opcode == HLT) n_halt = 1;
    end else begin
      n_valid = 0; n_wr = 0;
    end
    @(posedge clk);
    #1;
    e_valid = n_valid; e_wr = n_wr; e_halt = n_halt;
    e_result = n_result; e_dst = n_dst; e_flags = n_flags;
  endtask

  task automatic idle_inputs();
    rst = 0; ex_valid = 0; ex_opcode = ADD; ex_result = 0; ex_ovf = 0; ex_dst = 0;
    ex_wr_en = 0; stall = 0; flush = 0; br_eval = 0; br_cond = 0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] res, input logic ovf, input logic [3:0] dst);
    ex_valid = 1; ex_opcode = op; ex_result = res; ex_ovf = ovf; ex_dst = dst; ex_wr_en = 1;
  endtask

  task automatic test_reset();
    {ex_valid, ex_ovf, ex_wr_en, stall, flush, br_eval} = 6'($urandom);
    ex_opcode = 4'($urandom); ex_result = 16'($urandom); ex_dst = 4'($urandom);
    br_cond = 3'($urandom);
    rst = 1;
    tick();
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", mem_valid); end
    checks++; if (mem_result !== 16'h0) begin errors++; $display("FAIL reset_result got=%h want=0000", mem_result); end
    checks++; if (mem_dst !== 4'h0) begin errors++; $display("FAIL reset_dst got=%h want=0", mem_dst); end
    checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b want=0", mem_wr_en); end
    checks++; if (flags !== FLAG_RST) begin errors++; $display("FAIL reset_flags got=%b want=%b", flags, FLAG_RST); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b want=0", halted); end
    idle_inputs();
  endtask

  task automatic test_add_xor();
    issue(ADD, 16'h7FFF, 1'b1, 4'd3);
    tick();
    checks++; if (flags !== 3'b010) begin errors++; $display("FAIL add_sat_flags got=%b want=010", flags); end
    checks++; if (mem_result !== 16'h7FFF) begin errors++; $display("FAIL add_sat_result got=%h want=7fff", mem_result); end
    checks++; if (mem_valid !== 1'b1 || mem_wr_en !== 1'b1 || mem_dst !== 4'd3) begin
      errors++; $display("FAIL add_sat_ctrl got=v%b w%b d%0d want=v1 w1 d3", mem_valid, mem_wr_en, mem_dst); end
    issue(XOR, 16'h0000, 1'b0, 4'd4);
    tick();
    checks++; if (flags !== 3'b110) begin errors++; $display("FAIL xor_zero_flags got=%b want=110", flags); end
    issue(SUB, 16'h8000, 1'b0, 4'd5);
    tick();
    checks++; if (flags !== 3'b001) begin errors++; $display("FAIL sub_neg_flags got=%b want=001", flags); end
    issue(SLL, 16'h0010, 1'b1, 4'd6);
    tick();
    checks++; if (flags !== 3'b001) begin errors++; $display("FAIL sll_nz_flags got=%b want=001", flags); end
    idle_inputs();
  endtask

  task automatic test_stall_flush();
    logic [2:0]  f0;
    logic [15:0] r0;
    logic [3:0]  d0;
    issue(ADD, 16'h1234, 1'b0, 4'd7);
    tick();
    f0 = flags;
    issue(SUB, 16'h0000, 1'b1, 4'd8);
    stall = 1; flush = 1;
    tick();
    checks++; if (mem_valid !== 1'b0 || mem_wr_en !== 1'b0) begin
      errors++; $display("FAIL flush_stall_valid got=v%b w%b want=v0 w0", mem_valid, mem_wr_en); end
    checks++; if (flags !== f0) begin errors++; $display("FAIL flush_stall_flags got=%b want=%b", flags, f0); end
    flush = 0; stall = 0;
    issue(ADD, 16'h00A5, 1'b0, 4'd9);
    tick();
    f0 = flags; r0 = mem_result; d0 = mem_dst;
    issue(SUB, 16'h0000, 1'b1, 4'd1);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (mem_valid !== 1'b1 || mem_wr_en !== 1'b1 || flags !== f0 || mem_result !== r0 || mem_dst !== d0 || halted !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d] got=v%b w%b f%b r%h d%0d want=v1 w1 f%b r%h d%0d",
                 i, mem_valid, mem_wr_en, flags, mem_result, mem_dst, f0, r0, d0);
      end
    end
    idle_inputs();
  endtask

  task automatic test_branch();
    issue(ADD, 16'h0000, 1'b0, 4'd2);
    tick();
    idle_inputs();
    checks++; if (flags !== 3'b100) begin errors++; $display("FAIL br_setup_flags got=%b want=100", flags); end
    br_eval = 1; br_cond = 3'b001; #1;
    checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL br_eq got=%b want=1", br_taken); end
    br_cond = 3'b000; #1;
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL br_ne got=%b want=0", br_taken); end
    br_cond = 3'b100; #1;
    checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL br_ge got=%b want=1", br_taken); end
    br_eval = 0; br_cond = 3'b111; #1;
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL br_unc_noeval got=%b want=0", br_taken); end
    idle_inputs();
  endtask

  task automatic test_bypass();
    issue(ADD, 16'h0005, 1'b0, 4'd2);
    tick();
    issue(ADD, 16'h0000, 1'b0, 4'd3);
    br_eval = 1; br_cond = 3'b001; #1;
    checks++; if (br_taken !== BYPASS) begin errors++; $display("FAIL br_bypass got=%b want=%b", br_taken, BYPASS); end
    tick();
    idle_inputs();
  endtask

  task automatic test_halt();
    logic [2:0] f0;
    issue(HLT, 16'h0042, 1'b0, 4'd5);
    tick();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_set got=%b want=1", halted); end
    checks++; if (mem_valid !== 1'b1 || mem_wr_en !== 1'b0) begin
      errors++; $display("FAIL halt_slot got=v%b w%b want=v1 w0", mem_valid, mem_wr_en); end
    f0 = flags;
    for (int i = 0; i < 4; i++) begin
      issue(ADD, 16'h0000, 1'b1, 4'd6);
      tick();
      checks++;
      if (mem_valid !== 1'b0 || mem_wr_en !== 1'b0 || flags !== f0 || halted !== 1'b1) begin
        errors++;
        $display("FAIL halt_bubble[%0d] got=v%b w%b f%b h%b want=v0 w0 f%b h1", i, mem_valid, mem_wr_en, flags, halted, f0);
      end
    end
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear got=%b want=0", halted); end
  endtask

  task automatic test_random();
    logic [3:0] ops [8];
    ops = '{ADD, SUB, XOR, SLL, SRA, ROR, HLT, 4'b1000};
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      stall     = ($urandom_range(0, 6) == 0);
      ex_valid  = ($urandom_range(0, 4) != 0);
      ex_opcode = (i % 50 == 49) ? HLT : ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 9) == 0) ex_opcode = ops[$urandom_range(6, 7)];
      case ($urandom_range(0, 4))
        0: ex_result = 16'h0000;
        1: ex_result = 16'h7FFF;
        2: ex_result = 16'h8000;
        default: ex_result = 16'($urandom);
      endcase
      ex_ovf   = 1'($urandom);
      ex_dst   = 4'($urandom);
      ex_wr_en = 1'($urandom);
      br_eval  = ($urandom_range(0, 3) != 0);
      br_cond  = 3'($urandom);
      #1;
      checks++;
      if (br_taken !== exp_br()) begin
        errors++; $display("FAIL rnd_br[%0d] got=%b want=%b", i, br_taken, exp_br());
      end
      tick();
      checks++;
      if (mem_valid !== e_valid || mem_wr_en !== e_wr || flags !== e_flags || halted !== e_halt ||
          (e_valid && (mem_result !== e_result || mem_dst !== e_dst))) begin
        errors++;
        $display("FAIL rnd_out[%0d] got=v%b w%b f%b h%b r%h d%0d want=v%b w%b f%b h%b r%h d%0d", i,
                 mem_valid, mem_wr_en, flags, halted, mem_result, mem_dst,
                 e_valid, e_wr, e_flags, e_halt, e_result, e_dst);
      end
    end
    idle_inputs();
  endtask

  initial begin
    e_valid = 0; e_wr = 0; e_halt = 0; e_result = 0; e_dst = 0; e_flags = FLAG_RST;
    idle_inputs();
    #1;
    test_reset();
    test_add_xor();
    test_stall_flush();
    test_branch();
    test_bypass();
    test_halt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
